// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the QoS/age stream arbiter.
package stream_arb_pkg;

  // Packet-level arbitration state: IDLE = free to arbitrate, BURST = winner locked.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of a per-stream age counter able to hold 0..age_limit (at least 1 bit).
  function automatic int age_width(input int age_limit);
    int w;
    w = $clog2(age_limit + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry skid buffer: one cycle latency, full throughput, ready = not full.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = ~wr_q;
    if (pop)  rd_d = ~rd_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the buffer.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: it is only read while occupancy is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end

endmodule

// File: rtl/stream_arbiter_qos_age.sv
// Packet-locked stream arbiter: urgency (age) first, then QoS, then round-robin.
//
// Handshake: every stream port uses valid/ready. A beat transfers on a rising
// clock edge where valid and ready are both high; valid, once high, is held with
// stable payload until that transfer. s_ready_o may depend combinationally on
// s_valid_i (arbitration), never the other way around.
module stream_arbiter_qos_age
  import stream_arb_pkg::*;
#(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 4,
  parameter int T_ID___WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1,
  parameter int AGE_LIMIT    = 7,
  parameter int OUT_REG      = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rst,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
  output logic [T_ID___WIDTH-1:0]                   m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i,
  output arb_state_e                                dbg_state_o
);

  localparam int SW = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1;
  localparam int AW = age_width(AGE_LIMIT);
  localparam int PW = T_QOS__WIDTH + T_ID___WIDTH + 1 + T_DATA_WIDTH;
  localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);
  localparam logic [SW-1:0] RR_INIT = SW'(STREAM_COUNT - 1);

  arb_state_e                     state_q, state_d;
  logic [SW-1:0]                  grant_q, grant_d;
  logic [SW-1:0]                  rr_q, rr_d;
  logic [STREAM_COUNT-1:0][AW-1:0] age_q, age_d;
  logic [STREAM_COUNT-1:0]        urgent, cand;
  logic [SW-1:0]                  arb_id, eff_id;
  logic                           eff_valid, eff_last, down_ready;
  logic                           beat_hs, first_hs;
  logic [PW-1:0]                  beat_payload;

  assign dbg_state_o = state_q;

  // Candidate set: streams at the age limit pre-empt everyone else.
  always_comb begin
    urgent = '0;
    for (int i = 0; i < STREAM_COUNT; i++) begin
      urgent[i] = (AGE_LIMIT > 0) && s_valid_i[i] && (age_q[i] == AGE_MAX);
    end
    cand = (|urgent) ? urgent : s_valid_i;
  end

  // Highest QoS among candidates; strict '>' keeps the first hit in rr_q+1.. order.
  always_comb begin
    int                    idx;
    logic                  found;
    logic [T_QOS__WIDTH-1:0] best_qos;
    idx      = 0;
    found    = 1'b0;
    best_qos = '0;
    arb_id   = rr_q;
    for (int i = 1; i <= STREAM_COUNT; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= STREAM_COUNT) idx = idx - STREAM_COUNT;
      if (cand[idx] && (!found || (s_qos_i[idx] > best_qos))) begin
        found    = 1'b1;
        best_qos = s_qos_i[idx];
        arb_id   = SW'(idx);
      end
    end
  end

  assign eff_id       = (state_q == BURST) ? grant_q : arb_id;
  assign eff_valid    = (state_q == BURST) ? s_valid_i[eff_id] : (|s_valid_i);
  assign eff_last     = s_last_i[eff_id];
  assign beat_hs      = eff_valid & down_ready;
  assign first_hs     = beat_hs & (state_q == IDLE);
  assign beat_payload = {s_qos_i[eff_id], T_ID___WIDTH'(eff_id), eff_last, s_data_i[eff_id]};

  // Only the effective grant sees downstream ready; a locked grant keeps it even while stalled.
  always_comb begin
    s_ready_o = '0;
    if ((state_q == BURST) || (|s_valid_i)) s_ready_o[eff_id] = down_ready;
  end

  // Lock on a non-last transfer, unlock on a last transfer.
  always_comb begin
    state_d = state_q;
    if (beat_hs) state_d = eff_last ? IDLE : BURST;
  end

  // Packet lock state register.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Grant and round-robin pointer follow the winner of each first beat.
  always_comb begin
    grant_d = grant_q;
    rr_d    = rr_q;
    if (first_hs) begin
      grant_d = arb_id;
      rr_d    = arb_id;
    end
  end

  // Grant / round-robin registers.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      rr_q    <= RR_INIT;
    end else begin
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Ages move only on first beats: winner clears, other waiting streams count up to the limit.
  always_comb begin
    age_d = age_q;
    if (first_hs) begin
      for (int i = 0; i < STREAM_COUNT; i++) begin
        if (SW'(i) == arb_id)                           age_d[i] = '0;
        else if (s_valid_i[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  // Age registers.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end

  if (OUT_REG != 0) begin : g_skid
    logic [PW-1:0] out_payload;
    stream_skid_buffer #(.WIDTH(PW)) u_skid (
      .clk_i      (clk_i),
      .rst        (rst),
      .in_valid_i (eff_valid),
      .in_ready_o (down_ready),
      .in_data_i  (beat_payload),
      .out_valid_o(m_valid_o),
      .out_ready_i(m_ready_i),
      .out_data_o (out_payload)
    );
    assign {m_qos_o, m_id_o, m_last_o, m_data_o} = out_payload;
  end else begin : g_comb
    assign down_ready = m_ready_i;
    assign m_valid_o  = eff_valid;
    assign {m_qos_o, m_id_o, m_last_o, m_data_o} = beat_payload;
  end

endmodule
